// File: rtl/mlp_argmax_collector_if.sv
// ----------------------------------------------------------------------------
// mlp_argmax_collector_if
// Snooped output-buffer write bus of top_mlp.
//   y_buf_en     buffer enable
//   y_buf_wr_en  write enable
//   y_buf_addr   byte address (word-aligned when legal)
//   y_buf_data   signed score
// master: the MLP (or a bench driving it); slave: the argmax collector.
// ----------------------------------------------------------------------------
interface mlp_argmax_collector_if #(
    parameter int Y_BUF_ADDR_WIDTH = 32,
    parameter int Y_BUF_DATA_WIDTH = 32
) ();
    logic                        y_buf_en;
    logic                        y_buf_wr_en;
    logic [Y_BUF_ADDR_WIDTH-1:0] y_buf_addr;
    logic [Y_BUF_DATA_WIDTH-1:0] y_buf_data;

    modport master (
        output y_buf_en,
        output y_buf_wr_en,
        output y_buf_addr,
        output y_buf_data
    );

    modport slave (
        input y_buf_en,
        input y_buf_wr_en,
        input y_buf_addr,
        input y_buf_data
    );
endinterface

// File: rtl/mlp_argmax_collector.sv
// ----------------------------------------------------------------------------
// mlp_argmax_collector
// Snoops the MLP output-buffer writes, collects CLASS_NUM signed scores per
// image and tracks a running argmax per image (ties go to the lowest class).
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         run start; clears all collected state, enters COLLECT
//   y_buf           snooped write bus (slave modport)
//   mlp_done_i      MLP done; ends collection early
//   pred_vld_o      one-cycle pulse per finished image, with
//   pred_img_o      its image index and
//   pred_class_o    its winning class
//   rd_img_i        read-port image select
//   rd_class_o      stored class of rd_img_i (0 unless complete)
//   rd_valid_o      rd_img_i is complete
//   all_done_o      held high in DONE
//   err_o           sticky: bad address, duplicate class, or incomplete run
// Pipeline: stage 1 decodes/validates the beat, stage 2 updates the per-image
// mask/max/class and flags completion; the prediction is registered after.
// ----------------------------------------------------------------------------
module mlp_argmax_collector #(
    parameter  int IN_IMG_NUM       = 10,
    parameter  int CLASS_NUM        = 10,
    parameter  int Y_BUF_DATA_WIDTH = 32,
    parameter  int Y_BUF_ADDR_WIDTH = 32,
    localparam int IMGW             = $clog2(IN_IMG_NUM),
    localparam int CLSW             = $clog2(CLASS_NUM),
    localparam int WIDXW            = $clog2(IN_IMG_NUM * CLASS_NUM)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    mlp_argmax_collector_if.slave        y_buf,
    input  logic                         mlp_done_i,
    output logic                         pred_vld_o,
    output logic [IMGW-1:0]              pred_img_o,
    output logic [CLSW-1:0]              pred_class_o,
    input  logic [IMGW-1:0]              rd_img_i,
    output logic [CLSW-1:0]              rd_class_o,
    output logic                         rd_valid_o,
    output logic                         all_done_o,
    output logic                         err_o
);

    localparam int unsigned NWORDS   = IN_IMG_NUM * CLASS_NUM;
    localparam int unsigned CLS_U    = CLASS_NUM;
    localparam logic [IMGW-1:0] IMG_LAST = IMGW'(IN_IMG_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                              r_state;
    state_t                              w_state_nxt;
    logic                                r_flush_cnt;
    logic                                w_accept;

    logic                                r_s1_vld;
    logic [IMGW-1:0]                     r_s1_img;
    logic [CLSW-1:0]                     r_s1_cls;
    logic signed [Y_BUF_DATA_WIDTH-1:0]  r_s1_data;

    logic [IN_IMG_NUM-1:0][CLASS_NUM-1:0] r_mask;
    logic signed [Y_BUF_DATA_WIDTH-1:0]  r_max [IN_IMG_NUM];
    logic [CLSW-1:0]                     r_cls [IN_IMG_NUM];
    logic [IN_IMG_NUM-1:0]               r_img_done;

    logic                                r_pred_vld;
    logic [IMGW-1:0]                     r_pred_img;
    logic [CLSW-1:0]                     r_pred_class;
    logic                                r_err;

    // ------------------------------------------------------------------
    // Stage 1 decode (combinational part)
    // ------------------------------------------------------------------
    logic [WIDXW-1:0]  w_widx;
    logic              w_upper_set;
    logic              w_addr_ok;
    logic [IMGW-1:0]   w_img;
    logic [CLSW-1:0]   w_cls;
    logic              w_beat;

    assign w_widx      = y_buf.y_buf_addr[WIDXW+1:2];
    assign w_upper_set = |y_buf.y_buf_addr[Y_BUF_ADDR_WIDTH-1:WIDXW+2];
    assign w_addr_ok   = (y_buf.y_buf_addr[1:0] == 2'b00) && !w_upper_set
                         && (32'(w_widx) < NWORDS);
    assign w_img       = IMGW'(32'(w_widx) / CLS_U);
    assign w_cls       = CLSW'(32'(w_widx) % CLS_U);
    // A write coinciding with start_i belongs to the old run: drop it.
    assign w_beat      = w_accept && y_buf.y_buf_en && y_buf.y_buf_wr_en && !start_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_img  <= '0;
            r_s1_cls  <= '0;
            r_s1_data <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_s1_vld <= w_beat && w_addr_ok;
            if (w_beat) begin
                r_s1_img  <= w_img;
                r_s1_cls  <= w_cls;
                r_s1_data <= $signed(y_buf.y_buf_data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 update decision
    // ------------------------------------------------------------------
    logic [CLASS_NUM-1:0]  w_cur_mask;
    logic [CLASS_NUM-1:0]  w_cls_bit;
    logic [CLASS_NUM-1:0]  w_new_mask;
    logic                  w_dup;
    logic                  w_upd;
    logic                  w_take;
    logic                  w_completes;
    logic [CLSW-1:0]       w_win_cls;
    logic [IN_IMG_NUM-1:0] w_done_nxt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_cur_mask  = r_mask[r_s1_img];
        w_cls_bit   = {{(CLASS_NUM-1){1'b0}}, 1'b1} << r_s1_cls;
        w_new_mask  = w_cur_mask | w_cls_bit;
        w_dup       = r_s1_vld && (|(w_cur_mask & w_cls_bit));
        w_upd       = r_s1_vld && !w_dup;
        // Equal scores keep the lower class, so arrival order never matters.
        w_take      = (w_cur_mask == '0)
                      || (r_s1_data > r_max[r_s1_img])
                      || ((r_s1_data == r_max[r_s1_img]) && (r_s1_cls < r_cls[r_s1_img]));
        w_win_cls   = w_take ? r_s1_cls : r_cls[r_s1_img];
        w_completes = w_upd && (&w_new_mask);
        w_done_nxt  = r_img_done;
        if (w_completes) begin
            w_done_nxt = r_img_done | ({{(IN_IMG_NUM-1){1'b0}}, 1'b1} << r_s1_img);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-image tables are small flop arrays, not RAM, so
            // they are cleared by reset like any other state.
            r_mask     <= '0;
            r_img_done <= '0;
            for (int i = 0; i < IN_IMG_NUM; i++) begin
                r_max[i] <= '0;
                r_cls[i] <= '0;
            end
        end else if (start_i) begin
            r_mask     <= '0;
            r_img_done <= '0;
            for (int i = 0; i < IN_IMG_NUM; i++) begin
                r_max[i] <= '0;
                r_cls[i] <= '0;
            end
        end else begin
            r_img_done <= w_done_nxt;
            if (w_upd) begin
                r_mask[r_s1_img] <= w_new_mask;
                if (w_take) begin
                    r_max[r_s1_img] <= r_s1_data;
                    r_cls[r_s1_img] <= r_s1_cls;
                end
            end
        end
    end

    // Prediction pulse, one cycle after the completing update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_vld   <= 1'b0;
            r_pred_img   <= '0;
            r_pred_class <= '0;
        end else if (start_i) begin
            r_pred_vld   <= 1'b0;
            r_pred_img   <= '0;
            r_pred_class <= '0;
        end else begin
            r_pred_vld <= w_completes;
            if (w_completes) begin
                r_pred_img   <= r_s1_img;
                r_pred_class <= w_win_cls;
            end
        end
    end

    // Sticky error: bad address, duplicate class, or run ending incomplete.
    logic w_done_incomplete;
    assign w_done_incomplete = (r_state == S_FLUSH) && (w_state_nxt == S_DONE)
                               && !(&w_done_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (start_i) begin
            r_err <= 1'b0;
        end else if ((w_beat && !w_addr_ok) || w_dup || w_done_incomplete) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= (r_state == S_FLUSH) && (w_state_nxt == S_FLUSH);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start_i) begin
            w_state_nxt = S_COLLECT;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_IDLE;
                // Uses the post-update completion vector so the last image
                // finishing moves to FLUSH without an extra cycle.
                S_COLLECT: if (mlp_done_i || (&w_done_nxt)) w_state_nxt = S_FLUSH;
                S_FLUSH:   if (r_flush_cnt) w_state_nxt = S_DONE;
                S_DONE:    w_state_nxt = S_DONE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_accept   = (r_state == S_COLLECT) || (r_state == S_FLUSH);
        all_done_o = (r_state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Outputs and read port
    // ------------------------------------------------------------------
    assign pred_vld_o   = r_pred_vld;
    assign pred_img_o   = r_pred_img;
    assign pred_class_o = r_pred_class;
    assign err_o        = r_err;

    always_comb begin
        rd_valid_o = 1'b0;
        rd_class_o = '0;
        if ((rd_img_i <= IMG_LAST) && r_img_done[rd_img_i]) begin
            rd_valid_o = 1'b1;
            rd_class_o = r_cls[rd_img_i];
        end
    end

endmodule

// File: tb/tb_mlp_argmax_collector.sv
// ----------------------------------------------------------------------------
// tb_mlp_argmax_collector
// Scoreboard bench: each write updates a reference model; when an image's
// tenth distinct class arrives the expected {image, class} is queued, and a
// negedge monitor pops and compares it against every pred_vld_o pulse.
// ----------------------------------------------------------------------------
module tb_mlp_argmax_collector;

    localparam int IMG_N = 10;
    localparam int CLS_N = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       mlp_done_i = 1'b0;
    logic [3:0] rd_img_i = '0;
    logic       pred_vld_o;
    logic [3:0] pred_img_o;
    logic [3:0] pred_class_o;
    logic [3:0] rd_class_o;
    logic       rd_valid_o;
    logic       all_done_o;
    logic       err_o;

    mlp_argmax_collector_if #(
        .Y_BUF_ADDR_WIDTH(32),
        .Y_BUF_DATA_WIDTH(32)
    ) y_buf_bus ();

    mlp_argmax_collector #(
        .IN_IMG_NUM(IMG_N),
        .CLASS_NUM(CLS_N),
        .Y_BUF_DATA_WIDTH(32),
        .Y_BUF_ADDR_WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .y_buf       (y_buf_bus),
        .mlp_done_i  (mlp_done_i),
        .pred_vld_o  (pred_vld_o),
        .pred_img_o  (pred_img_o),
        .pred_class_o(pred_class_o),
        .rd_img_i    (rd_img_i),
        .rd_class_o  (rd_class_o),
        .rd_valid_o  (rd_valid_o),
        .all_done_o  (all_done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int img;
        int cls;
    } pred_t;

    pred_t sb_q[$];
    bit    m_mask  [IMG_N][CLS_N];
    int    m_score [IMG_N][CLS_N];
    bit    m_done  [IMG_N];
    int    m_cls   [IMG_N];
    bit    m_err;
    bit    m_active;

    function automatic void model_clear();
        for (int i = 0; i < IMG_N; i++) begin
            m_done[i] = 1'b0;
            m_cls[i]  = 0;
            for (int c = 0; c < CLS_N; c++) begin
                m_mask[i][c]  = 1'b0;
                m_score[i][c] = 0;
            end
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input int data);
        int widx;
        int img;
        int c;
        int best;
        if (!m_active) return;
        if (addr[1:0] != 2'b00 || addr >= 32'(IMG_N * CLS_N * 4)) begin
            m_err = 1'b1;
            return;
        end
        widx = int'(addr >> 2);
        img  = widx / CLS_N;
        c    = widx % CLS_N;
        if (m_mask[img][c]) begin
            m_err = 1'b1;
            return;
        end
        m_mask[img][c]  = 1'b1;
        m_score[img][c] = data;
        for (int k = 0; k < CLS_N; k++) if (!m_mask[img][k]) return;
        best = 0;
        for (int k = 1; k < CLS_N; k++) if (m_score[img][k] > m_score[img][best]) best = k;
        m_done[img] = 1'b1;
        m_cls[img]  = best;
        sb_q.push_back('{img, best});
    endfunction

    always @(negedge clk) begin : monitor
        pred_t p;
        if (pred_vld_o) begin
            if (sb_q.size() == 0) begin
                check("pred_unexpected", 32'd1, 32'd0);
            end else begin
                p = sb_q.pop_front();
                check("pred_img", 32'(pred_img_o), p.img);
                check("pred_class", 32'(pred_class_o), p.cls);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input int data);
        y_buf_bus.y_buf_en    = 1'b1;
        y_buf_bus.y_buf_wr_en = 1'b1;
        y_buf_bus.y_buf_addr  = addr;
        y_buf_bus.y_buf_data  = data;
        model_write(addr, data);
        tick();
        y_buf_bus.y_buf_en    = 1'b0;
        y_buf_bus.y_buf_wr_en = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        model_clear();
        m_active = 1'b1;
    endtask

    task automatic check_reads(input string tag);
        bit v;
        for (int i = 0; i < 16; i++) begin
            rd_img_i = 4'(i);
            #1;
            v = (i < IMG_N) ? m_done[i] : 1'b0;
            check($sformatf("%s_rdv%0d", tag, i), 32'(rd_valid_o), 32'(v));
            check($sformatf("%s_rdc%0d", tag, i), 32'(rd_class_o), v ? m_cls[i] : 0);
        end
        rd_img_i = '0;
    endtask

    task automatic rd_expect(input string tag, input int img, input bit v, input int cls);
        rd_img_i = 4'(img);
        #1;
        check({tag, "_v"}, 32'(rd_valid_o), 32'(v));
        check({tag, "_c"}, 32'(rd_class_o), cls);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int sc;
        y_buf_bus.y_buf_en    = 1'b0;
        y_buf_bus.y_buf_wr_en = 1'b0;
        y_buf_bus.y_buf_addr  = '0;
        y_buf_bus.y_buf_data  = '0;
        m_active = 1'b0;
        model_clear();

        // Reset state
        #12;
        check("rst_pred_vld", 32'(pred_vld_o), 0);
        check("rst_all_done", 32'(all_done_o), 0);
        check("rst_err", 32'(err_o), 0);
        rd_expect("rst_rd0", 0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // IDLE: mlp_done and writes ignored
        mlp_done_i = 1'b1;
        tick();
        mlp_done_i = 1'b0;
        wr(32'h0, 7);
        repeat (3) tick();
        check("idle_all_done", 32'(all_done_o), 0);
        check("idle_err", 32'(err_o), 0);
        rd_expect("idle_rd0", 0, 1'b0, 0);

        // T1: in-order run
        do_start();
        for (int w = 0; w < IMG_N * CLS_N; w++) begin
            sc = ((w % CLS_N) == (w / CLS_N) % 10) ? 1000 : (w % CLS_N);
            wr(32'(w * 4), sc);
        end
        tick();
        tick();
        check("t1_all_done_2", 32'(all_done_o), 0);
        tick();
        check("t1_all_done_3", 32'(all_done_o), 1);
        check("t1_err", 32'(err_o), 32'(m_err));
        check_reads("t1");
        check("t1_sb_empty", sb_q.size(), 0);
        m_active = 1'b0;
        // DONE: writes ignored (would be a duplicate otherwise)
        wr(32'h0, 5000);
        repeat (3) tick();
        check("t1_done_wr_err", 32'(err_o), 0);
        rd_expect("t1_done_rd0", 0, 1'b1, 0);

        // T2: reverse order, ties and negative maxima
        do_start();
        for (int w = IMG_N * CLS_N - 1; w >= 0; w--) begin
            if (w / CLS_N == 0)      sc = -100 + (w % CLS_N);
            else if (w / CLS_N == 3) sc = -5;
            else                     sc = int'($urandom_range(0, 6)) - 3;
            wr(32'(w * 4), sc);
        end
        repeat (4) tick();
        check("t2_all_done", 32'(all_done_o), 1);
        check("t2_err", 32'(err_o), 0);
        rd_expect("t2_tie_img3", 3, 1'b1, 0);
        rd_expect("t2_neg_img0", 0, 1'b1, 9);
        check_reads("t2");

        // T3: duplicate and illegal addresses
        do_start();
        wr(32'h004, 5);
        tick();
        tick();
        check("t3_err_before", 32'(err_o), 0);
        wr(32'h004, 999);
        tick();
        check("t3_err_dup", 32'(err_o), 1);
        wr(32'h002, 999);
        wr(32'h190, 999);
        wr(32'h200, 999);
        for (int c = 0; c < CLS_N; c++) if (c != 1) wr(32'(c * 4), 0);
        repeat (3) tick();
        rd_expect("t3_img0", 0, 1'b1, 1);
        check("t3_err_model", 32'(err_o), 32'(m_err));

        // T4: early done after five images
        do_start();
        check("t4_err_cleared", 32'(err_o), 0);
        for (int w = 0; w < 50; w++) begin
            sc = ((w % CLS_N) == ((w / CLS_N) + 3) % CLS_N) ? 77 : -(w % CLS_N);
            wr(32'(w * 4), sc);
        end
        repeat (3) tick();
        mlp_done_i = 1'b1;
        tick();
        mlp_done_i = 1'b0;
        check("t4_flush_1", 32'(all_done_o), 0);
        tick();
        check("t4_flush_2", 32'(all_done_o), 0);
        tick();
        check("t4_all_done", 32'(all_done_o), 1);
        check("t4_err", 32'(err_o), 1);
        rd_expect("t4_img4", 4, 1'b1, 7);
        rd_expect("t4_img5", 5, 1'b0, 0);
        check_reads("t4");

        // T5: start coincident with a write in COLLECT
        do_start();
        check_reads("t5_clear");
        check("t5_err_clear", 32'(err_o), 0);
        start_i = 1'b1;
        y_buf_bus.y_buf_en    = 1'b1;
        y_buf_bus.y_buf_wr_en = 1'b1;
        y_buf_bus.y_buf_addr  = 32'h0;
        y_buf_bus.y_buf_data  = 42;
        tick();
        start_i = 1'b0;
        y_buf_bus.y_buf_en    = 1'b0;
        y_buf_bus.y_buf_wr_en = 1'b0;
        model_clear();
        for (int c = 1; c < CLS_N; c++) wr(32'(c * 4), c);
        repeat (3) tick();
        rd_expect("t5_dropped", 0, 1'b0, 0);
        check("t5_err", 32'(err_o), 0);
        wr(32'h0, 42);
        repeat (3) tick();
        rd_expect("t5_img0", 0, 1'b1, 0);

        // T6: reset mid-run
        do_start();
        for (int w = 0; w < 25; w++) wr(32'(w * 4), (w % CLS_N) * 2);
        repeat (3) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        rd_img_i = 4'd0;
        #1;
        check("t6_rst_pred", 32'(pred_vld_o), 0);
        check("t6_rst_done", 32'(all_done_o), 0);
        check("t6_rst_err", 32'(err_o), 0);
        check("t6_rst_rdv", 32'(rd_valid_o), 0);
        m_active = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_start();
        for (int w = 0; w < IMG_N * CLS_N; w++) begin
            sc = ((w % CLS_N) == 9 - (w / CLS_N)) ? 500 : (w % CLS_N) * 3 - 20;
            wr(32'(w * 4), sc);
        end
        repeat (4) tick();
        check("t6_all_done", 32'(all_done_o), 1);
        check("t6_err", 32'(err_o), 0);
        check_reads("t6");

        repeat (2) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/mlp_argmax_collector.md
Name: mlp_argmax_collector

Overview:
- Sits directly downstream of top_mlp and snoops its output-buffer write stream (y_buf_en, y_buf_wr_en, y_buf_addr, y_buf_data).
- Collects the CLASS_NUM signed 32-bit scores of each image and computes a per-image argmax.
- Emits a prediction pulse per finished image and holds all predictions in a readable register file.
- Raises a sticky completion flag once the MLP reports done and the pipeline has drained.

Parameters:
- IN_IMG_NUM, 10, number of images per run.
- CLASS_NUM, 10, scores per image.
- Y_BUF_DATA_WIDTH, 32, score width (signed two's complement).
- Y_BUF_ADDR_WIDTH, 32, byte address width of the snooped bus.
- Derived, not overridable: IMGW = $clog2(IN_IMG_NUM); CLSW = $clog2(CLASS_NUM); WIDXW = $clog2(IN_IMG_NUM*CLASS_NUM).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  run start pulse; clears all collected state.
- y_buf_en  in  1  snooped buffer enable.
- y_buf_wr_en  in  1  snooped write enable.
- y_buf_addr  in  Y_BUF_ADDR_WIDTH  snooped byte address, word-aligned.
- y_buf_data  in  Y_BUF_DATA_WIDTH  snooped score.
- mlp_done_i  in  1  done_intr_o from the MLP.
- pred_vld_o  out  1  one-cycle pulse: an image's argmax is final.
- pred_img_o  out  IMGW  image index for pred_vld_o.
- pred_class_o  out  CLSW  winning class for pred_vld_o.
- rd_img_i  in  IMGW  read-port image select.
- rd_class_o  out  CLSW  stored class for rd_img_i (combinational).
- rd_valid_o  out  1  rd_img_i image complete (combinational).
- all_done_o  out  1  sticky, set in DONE.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0, all per-image masks, max values and classes cleared, FSM in IDLE.
- FSM states and transitions:
  - IDLE -> COLLECT on start_i.
  - COLLECT -> FLUSH on mlp_done_i, or when all IN_IMG_NUM images are complete.
  - FLUSH waits exactly 2 cycles to drain the pipeline, then -> DONE.
  - DONE holds all_done_o=1; DONE -> COLLECT on start_i.
- start_i in any state (including COLLECT/FLUSH): clear masks, maxima, classes, err_o, all_done_o; enter COLLECT next cycle. A write in the same cycle as start_i is dropped.
- Write acceptance: only when y_buf_en & y_buf_wr_en in COLLECT or FLUSH. Writes in IDLE/DONE are ignored with no error.
- Stage 1 (registered): decode widx = y_buf_addr[WIDXW+1:2]; img = widx / CLASS_NUM; cls = widx % CLASS_NUM. Latch data, img, cls and a valid bit.
- Address check in stage 1: the address is illegal if y_buf_addr[1:0] != 0, any bit above WIDXW+1 is set, or widx >= IN_IMG_NUM*CLASS_NUM. An illegal address sets err_o and the beat is discarded.
- Stage 2 (update): per-image class mask bit cls.
  - If the bit is already set: duplicate; set err_o and ignore the data.
  - Otherwise set the bit. If this is the first class for the image, or data > stored max (signed), or data == stored max and cls < stored class, replace max and class.
  - Ties therefore resolve to the lowest class index, independent of arrival order.
- Completion: when an update sets the image's mask to all-ones, pred_vld_o pulses in the next cycle with pred_img_o/pred_class_o. Latency is 2 cycles from the 10th accepted write to the pred_vld_o edge. Back-to-back writes are sustained at one per cycle, and completions of different images may pulse on consecutive cycles.
- Entering DONE with any image incomplete sets err_o. all_done_o is still set.
- Read port: rd_class_o = stored class, rd_valid_o = image complete. Both are 0 if rd_img_i >= IN_IMG_NUM or the image is incomplete.
- mlp_done_i in IDLE or DONE is ignored.

Test Plan:
- In-order run: start_i, then 100 writes, addr 0x000..0x18C step 4; image k scores = class index c except class (k%10) = 1000 -> pred_vld_o 10 times, pred_class_o = k%10; all_done_o=1 three cycles after the last write (2-cycle pipeline + FLUSH); err_o=0.
- Reverse-order writes with ties: all scores of image 3 = -5 -> pred_class_o=0 for image 3; negative max: image 0 scores -100..-91 with class 9 = -91 -> class 9.
- Duplicate and illegal addresses: writes to 0x004 twice, 0x002, 0x190 -> err_o=1 after the first duplicate; data of the dup/illegal beats does not change rd_class_o.
- Early done: 50 writes (images 0-4), then mlp_done_i -> FLUSH 2 cycles, DONE, all_done_o=1, err_o=1; rd_valid_o=1 for rd_img_i=4, 0 for 5.
- start_i coincident with a write in COLLECT -> write dropped, all rd_valid_o=0, err_o=0, state COLLECT.
- rst_n asserted mid-run (image 2 half collected) -> all outputs 0 immediately; a new start_i and full run yields correct results.
